// File: rtl/squeeze_output_stage.sv
// Output stage of the SHAKE pipeline: holds one squeezed rate block and drains
// it as a length-trimmed valid/ready word stream.
module squeeze_output_stage #(
    parameter int WORD_WIDTH = 64,
    parameter int RATE_MAX   = 1344
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RATE_MAX-1:0]   rate_input,
    input  logic [1:0]            operation_mode_in,
    input  logic [31:0]           output_size_in,
    input  logic                  output_buffer_we,
    input  logic                  output_buffer_available_clr,
    input  logic                  last_output_block_wr,
    output logic                  output_buffer_available,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);

    localparam int          RATE_WORDS   = RATE_MAX / WORD_WIDTH;
    localparam int          SHIFT_W      = $clog2(WORD_WIDTH);
    localparam logic [4:0]  LAST_IDX_128 = 5'(RATE_WORDS - 1);
    localparam logic [4:0]  LAST_IDX_256 = 5'(1088 / WORD_WIDTH - 1);
    localparam logic [31:0] WORD_BITS    = 32'(WORD_WIDTH);

    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic [31:0] sat_sub_word(input logic [31:0] rem);
        return (rem > WORD_BITS) ? rem - WORD_BITS : '0;
    endfunction

    // Bits at or above the remaining length are forced to zero on a short word.
    function automatic logic [WORD_WIDTH-1:0] trim_word(input logic [WORD_WIDTH-1:0] w,
                                                        input logic [31:0] rem);
        logic [WORD_WIDTH-1:0] mask;
        mask = '1;
        if (rem < WORD_BITS) mask = ~({WORD_WIDTH{1'b1}} << rem[SHIFT_W-1:0]);
        return w & mask;
    endfunction

    state_t                state_q, state_d;
    logic                  avail_q, avail_d;
    logic                  in_msg_q, in_msg_d;
    logic [31:0]           rem_q, rem_d;
    logic [4:0]            idx_q, idx_d;
    logic                  mode128_q, mode128_d;
    logic                  last_flag_q, last_flag_d;
    logic [WORD_WIDTH-1:0] buf_q [RATE_WORDS];
    logic [WORD_WIDTH-1:0] buf_d [RATE_WORDS];

    logic                  fire;
    logic                  final_word;
    logic                  avail_set;
    logic [WORD_WIDTH-1:0] cur_word;

    assign cur_word                = buf_q[idx_q];
    assign data_out_valid          = (state_q == DRAIN) && (rem_q != '0);
    assign fire                    = data_out_valid && data_out_ready;
    assign final_word              = (idx_q == (mode128_q ? LAST_IDX_128 : LAST_IDX_256))
                                     || (rem_q <= WORD_BITS);
    assign data_out_last           = data_out_valid && final_word
                                     && ((rem_q <= WORD_BITS) || last_flag_q);
    assign data_out                = data_out_valid ? trim_word(cur_word, rem_q) : '0;
    assign output_buffer_available = avail_q;

    always_comb begin
        state_d     = state_q;
        in_msg_d    = in_msg_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        mode128_d   = mode128_q;
        last_flag_d = last_flag_q;
        buf_d       = buf_q;
        avail_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (output_buffer_we) begin
                    for (int i = 0; i < RATE_WORDS; i++) begin
                        buf_d[i] = rate_input[i*WORD_WIDTH +: WORD_WIDTH];
                    end
                    mode128_d   = (operation_mode_in == 2'b00);
                    last_flag_d = last_output_block_wr;
                    if (!in_msg_q) begin
                        rem_d    = output_size_in;
                        in_msg_d = 1'b1;
                    end
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing left to send for this message: close the block without words.
                if (rem_q == '0) begin
                    state_d   = IDLE;
                    avail_set = 1'b1;
                    in_msg_d  = 1'b0;
                end else if (fire) begin
                    idx_d = idx_q + 5'd1;
                    rem_d = sat_sub_word(rem_q);
                    if (final_word) begin
                        state_d   = IDLE;
                        avail_set = 1'b1;
                    end
                    if (data_out_last) in_msg_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // The permute stage's clear takes priority over the end-of-drain set.
        if (output_buffer_available_clr) avail_d = 1'b0;
        else if (avail_set)              avail_d = 1'b1;
        else                             avail_d = avail_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            avail_q     <= 1'b1;
            in_msg_q    <= 1'b0;
            rem_q       <= '0;
            idx_q       <= '0;
            mode128_q   <= 1'b1;
            last_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            avail_q     <= avail_d;
            in_msg_q    <= in_msg_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            mode128_q   <= mode128_d;
            last_flag_q <= last_flag_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule
